// File: rtl/dac_5390_sequencer.sv
// Batches host channel writes and sequences them through the dac_5390 driver.
// Define DAC_SEQ_AUTO_INIT_EN to send INIT_WORD automatically after reset.
module dac_5390_sequencer #(
  parameter int          FIFO_DEPTH    = 16,
  parameter int          TRIG_LEN      = 4,
  parameter int          LDAC_LEN      = 4,
  parameter int          READY_TIMEOUT = 255,
  parameter logic [23:0] INIT_WORD     = 24'h0C3E00
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          wr_en_i,
  input  logic [3:0]                    wr_chan_i,
  input  logic [13:0]                   wr_data_i,
  input  logic                          commit_i,
  input  logic                          init_req_i,
  input  logic                          clr_err_i,
  input  logic                          dac_ready_i,
  output logic [23:0]                   dac_data_o,
  output logic                          dac_trig_o,
  output logic                          dac_init_o,
  output logic                          dac_ldac_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          full_o,
  output logic                          busy_o,
  output logic                          batch_done_o,
  output logic                          timeout_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE, LOAD, TRIG, WAIT_ACK, WAIT_DONE, NEXT, LDAC, DONE
  } state_t;

  state_t         state, state_n;
  logic [17:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    level, batch_cnt;
  logic [CW-1:0]  cnt;
  logic [17:0]    head;
  logic           pend, init_go, push, pop, abort;
  logic           start_init, start_data, load_word;

  assign head    = mem[rd_ptr];
  assign level_o = level;
  assign full_o  = level == (AW+1)'(FIFO_DEPTH);
  assign push    = wr_en_i & ~full_o;

`ifdef DAC_SEQ_AUTO_INIT_EN
  logic auto_pend;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) auto_pend <= 1'b1;
    else if (state == IDLE) auto_pend <= 1'b0;
  end

  assign init_go = init_req_i | auto_pend;
`else
  assign init_go = init_req_i;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + CW'(1);
    end
  end

  always_comb begin
    state_n    = state;
    start_init = 1'b0;
    start_data = 1'b0;
    load_word  = 1'b0;
    abort      = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (init_go) begin
          state_n    = LOAD;
          start_init = 1'b1;
        end else if ((commit_i | pend) && level != '0) begin
          state_n    = LOAD;
          start_data = 1'b1;
        end
      end
      LOAD: state_n = TRIG;
      TRIG: begin
        if (cnt == CW'(TRIG_LEN - 1)) state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!dac_ready_i) begin
          state_n = WAIT_DONE;
        end else if (cnt == CW'(READY_TIMEOUT - 1)) begin
          state_n = IDLE;
          abort   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (dac_ready_i) begin
          state_n = NEXT;
          pop     = ~dac_init_o;
        end else if (cnt == CW'(READY_TIMEOUT - 1)) begin
          state_n = IDLE;
          abort   = 1'b1;
        end
      end
      NEXT: begin
        if (dac_init_o) begin
          state_n = IDLE;
        end else if (batch_cnt != '0) begin
          state_n   = LOAD;
          load_word = 1'b1;
        end else begin
          state_n = LDAC;
        end
      end
      LDAC: begin
        if (cnt == CW'(LDAC_LEN - 1)) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dac_trig_o   = 1'b0;
    dac_ldac_o   = 1'b0;
    batch_done_o = 1'b0;
    busy_o       = state != IDLE;
    unique case (state)
      TRIG:    dac_trig_o   = 1'b1;
      LDAC:    dac_ldac_o   = 1'b1;
      DONE:    batch_done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push && !abort) mem[wr_ptr] <= {wr_chan_i, wr_data_i};
  end

  // An abort flushes everything, including a write landing in the same cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (abort) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend      <= 1'b0;
      batch_cnt <= '0;
    end else begin
      if (abort)
        pend <= 1'b0;
      else if (commit_i && (state != IDLE || init_go))
        pend <= 1'b1;
      else if (state == IDLE && !init_go)
        pend <= 1'b0;
      if (start_data)
        batch_cnt <= level;
      else if (pop)
        batch_cnt <= batch_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dac_data_o <= '0;
      dac_init_o <= 1'b0;
    end else if (start_init) begin
      dac_data_o <= INIT_WORD;
      dac_init_o <= 1'b1;
    end else if (start_data || load_word) begin
      dac_data_o <= {4'b0000, head[17:14], 2'b11, head[13:0]};
      dac_init_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      timeout_o  <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (abort) timeout_o <= 1'b1;
      else if (clr_err_i) timeout_o <= 1'b0;
      if (wr_en_i && full_o) overflow_o <= 1'b1;
      else if (clr_err_i) overflow_o <= 1'b0;
    end
  end

endmodule
